// File: rtl/ip_pack.sv
// IPv4 header packer: latches a send request, computes the header checksum,
// then streams the 20-byte header followed by the payload to the MAC.
module ip_pack #(
  parameter logic [7:0]  TTL     = 8'd64,
  parameter logic [15:0] MAX_LEN = 16'd1480
) (
  input  logic        tx_clk,
  input  logic        rst_n,
  input  logic [31:0] src_ip_addr,
  input  logic [31:0] des_ip_addr,
  input  logic [7:0]  trans_prot_type,
  input  logic [15:0] trans_pkt_len,
  input  logic        trans_pkt_start,
  output logic        trans_pkt_rd,
  input  logic [7:0]  trans_pkt_dat,
  output logic        trans_pkt_drop,
  output logic        tx_busy,
  output logic        ip_pkt_start,
  output logic        ip_pkt_en,
  output logic        ip_pkt_end,
  output logic [7:0]  ip_pkt_dat,
  output logic [15:0] ip_prot_type
);

  typedef enum logic [2:0] {S_IDLE, S_CSUM, S_HEAD, S_DATA, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [15:0] r_cnt;
  logic [15:0] r_ident;
  logic [15:0] r_len;
  logic [31:0] r_src, r_des;
  logic [7:0]  r_prot;
  logic [19:0] r_sum;
  logic [15:0] r_csum;
  logic        r_drop;

  logic        w_start_ok;
  logic        w_last_data;
  logic [15:0] w_total;
  logic [16:0] w_fold1;
  logic [15:0] w_fold2;
  logic [7:0]  w_hdr;

  assign w_start_ok  = trans_pkt_start && (trans_pkt_len != 16'd0) && (trans_pkt_len <= MAX_LEN);
  assign w_last_data = (r_cnt == r_len - 16'd1);
  assign w_total     = r_len + 16'd20;
  // Ten words never exceed 20 bits, so two end-around folds are enough.
  assign w_fold1     = {1'b0, r_sum[15:0]} + {13'd0, r_sum[19:16]};
  assign w_fold2     = w_fold1[15:0] + {15'd0, w_fold1[16]};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start_ok) w_next = S_CSUM;
      S_CSUM: if (r_cnt == 16'd3) w_next = S_HEAD;
      S_HEAD: if (r_cnt == 16'd19) w_next = S_DATA;
      S_DATA: if (w_last_data) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_hdr = 8'h00;
    case (r_cnt)
      16'd0:  w_hdr = 8'h45;
      16'd2:  w_hdr = w_total[15:8];
      16'd3:  w_hdr = w_total[7:0];
      16'd4:  w_hdr = r_ident[15:8];
      16'd5:  w_hdr = r_ident[7:0];
      16'd6:  w_hdr = 8'h40;
      16'd8:  w_hdr = TTL;
      16'd9:  w_hdr = r_prot;
      16'd10: w_hdr = r_csum[15:8];
      16'd11: w_hdr = r_csum[7:0];
      16'd12: w_hdr = r_src[31:24];
      16'd13: w_hdr = r_src[23:16];
      16'd14: w_hdr = r_src[15:8];
      16'd15: w_hdr = r_src[7:0];
      16'd16: w_hdr = r_des[31:24];
      16'd17: w_hdr = r_des[23:16];
      16'd18: w_hdr = r_des[15:8];
      16'd19: w_hdr = r_des[7:0];
      default: w_hdr = 8'h00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge tx_clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ident <= '0;
      r_len   <= '0;
      r_src   <= '0;
      r_des   <= '0;
      r_prot  <= '0;
      r_sum   <= '0;
      r_csum  <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_drop  <= (r_state == S_IDLE) && trans_pkt_start && !w_start_ok;
      r_cnt   <= (w_next != r_state) ? 16'd0 : r_cnt + 16'd1;
      if (r_state == S_IDLE && w_start_ok) begin
        r_src  <= src_ip_addr;
        r_des  <= des_ip_addr;
        r_prot <= trans_prot_type;
        r_len  <= trans_pkt_len;
      end
      // Checksum is accumulated over the four CSUM cycles and folded in the last.
      if (r_state == S_CSUM) begin
        case (r_cnt)
          16'd0: r_sum <= 20'h04500 + {4'd0, w_total} + {4'd0, r_ident} + 20'h04000;
          16'd1: r_sum <= r_sum + {4'd0, TTL, r_prot} + {4'd0, r_src[31:16]} + {4'd0, r_src[15:0]};
          16'd2: r_sum <= r_sum + {4'd0, r_des[31:16]} + {4'd0, r_des[15:0]};
          default: r_csum <= ~w_fold2;
        endcase
      end
      if (r_state == S_DATA && w_next == S_DONE) r_ident <= r_ident + 16'd1;
    end
  end

  assign ip_pkt_start   = (r_state == S_CSUM) && (r_cnt == 16'd3);
  assign ip_pkt_en      = (r_state == S_HEAD) || (r_state == S_DATA);
  assign ip_pkt_end     = (r_state == S_DONE);
  assign trans_pkt_rd   = ((r_state == S_HEAD) && (r_cnt == 16'd19)) ||
                          ((r_state == S_DATA) && !w_last_data);
  assign tx_busy        = (r_state != S_IDLE);
  assign trans_pkt_drop = r_drop;
  assign ip_pkt_dat     = (r_state == S_HEAD) ? w_hdr :
                          (r_state == S_DATA) ? trans_pkt_dat : 8'h00;
  assign ip_prot_type   = 16'h0800;

endmodule
